// File: rtl/rv_mem_pkg.sv
// Shared types for the memory-port arbiter: response-stage states and port-select encoding.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_D    = 2'd2,
    RSP_DERR = 2'd3
  } rsp_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_sel_t;

  // A data access is misaligned when its byte offset inside the word is non-zero.
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return (byte_off != 2'b00);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared single-port memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) ();

  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              mem_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-request round-robin picker; grants are combinational, last_grant is the only state.
module rr_arb2
  import rv_mem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_if,
  input  logic req_d,
  output logic gnt_if,
  output logic gnt_d
);

  port_sel_t last_grant_r;

  // Pick a winner; on conflict the port that did not win most recently goes first.
  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (en && !reset) begin
      if (req_if && req_d) begin
        if (last_grant_r == PORT_IF) begin
          gnt_d = 1'b1;
        end else begin
          gnt_if = 1'b1;
        end
      end else if (req_if) begin
        gnt_if = 1'b1;
      end else if (req_d) begin
        gnt_d = 1'b1;
      end else begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
      end
    end else begin
      gnt_if = 1'b0;
      gnt_d  = 1'b0;
    end
  end

  // Remember which port won; fetch by default so data wins the first conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_r <= PORT_IF;
    end else if (gnt_if) begin
      last_grant_r <= PORT_IF;
    end else if (gnt_d) begin
      last_grant_r <= PORT_D;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory between an instruction-fetch port and a data port,
// one access per cycle, with a one-cycle read response stage.
module mem_port_arbiter
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [DATA_W-1:0] ZERO_DATA = '0;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

  logic       gnt_if_s;
  logic       gnt_d_s;
  logic       d_mis_s;
  rsp_state_t next_s;
  rsp_state_t state_r;
  logic       if_rvalid_r;
  logic       d_rvalid_r;
  logic       d_err_r;
  logic       unused_s;

  // Byte offsets and address bits above the memory size carry no meaning here.
  assign unused_s = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0], bus.d_addr[31:ADDR_W+2]};
  assign d_mis_s  = is_misaligned(bus.d_addr[1:0]);

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .en     (bus.mem_ready),
    .req_if (bus.if_req),
    .req_d  (bus.d_req),
    .gnt_if (gnt_if_s),
    .gnt_d  (gnt_d_s)
  );

  // Steer the granted port onto the memory; misaligned data accesses never strobe it.
  always_comb begin
    bus.if_gnt    = gnt_if_s;
    bus.d_gnt     = gnt_d_s;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = ZERO_ADDR;
    bus.mem_wdata = ZERO_DATA;
    if (gnt_d_s) begin
      bus.mem_en    = !d_mis_s;
      bus.mem_we    = bus.d_we;
      bus.mem_addr  = bus.d_addr[ADDR_W+1:2];
      bus.mem_wdata = bus.d_wdata;
    end else if (gnt_if_s) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = bus.if_addr[ADDR_W+1:2];
      bus.mem_wdata = ZERO_DATA;
    end else begin
      bus.mem_en    = 1'b0;
    end
  end

  // Decide which response the next cycle owes.
  always_comb begin
    next_s = RSP_NONE;
    if (gnt_if_s) begin
      next_s = RSP_IF;
    end else if (gnt_d_s) begin
      if (d_mis_s) begin
        next_s = RSP_DERR;
      end else if (!bus.d_we) begin
        next_s = RSP_D;
      end else begin
        next_s = RSP_NONE;
      end
    end else begin
      next_s = RSP_NONE;
    end
  end

  // Response-stage FSM with its valid/error flags registered alongside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= RSP_NONE;
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      d_err_r     <= 1'b0;
    end else begin
      state_r     <= next_s;
      if_rvalid_r <= (next_s == RSP_IF);
      d_rvalid_r  <= (next_s == RSP_D) || (next_s == RSP_DERR);
      d_err_r     <= (next_s == RSP_DERR);
    end
  end

  // Read data passes through only in the owning response state; zero otherwise.
  always_comb begin
    bus.if_rvalid = if_rvalid_r;
    bus.d_rvalid  = d_rvalid_r;
    bus.d_err     = d_err_r;
    bus.if_rdata  = ZERO_DATA;
    bus.d_rdata   = ZERO_DATA;
    case (state_r)
      RSP_IF:   bus.if_rdata = bus.mem_rdata;
      RSP_D:    bus.d_rdata  = bus.mem_rdata;
      RSP_DERR: bus.d_rdata  = ZERO_DATA;
      RSP_NONE: bus.d_rdata  = ZERO_DATA;
      default:  bus.d_rdata  = ZERO_DATA;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_mem_port_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Model state: which port won last (0 fetch, 1 data) and the response owed next cycle.
  int m_last = 0;
  int m_pend = 0;   // 0 none, 1 fetch read, 2 data read, 3 data error
  int last_g = -1;  // grant of the most recent cycle: -1 none, 0 fetch, 1 data

  logic            s_if_gnt, s_d_gnt, s_mem_en, s_mem_we;
  logic            s_if_rvalid, s_d_rvalid, s_d_err;
  logic [AW-1:0]   s_mem_addr;
  logic [DW-1:0]   s_if_rdata, s_d_rdata;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: predict, sample at the falling edge, compare, then advance the model.
  task automatic run_cycle();
    int g;
    logic [63:0] e_en, e_we, e_addr, e_wdata, e_ifv, e_ifd, e_dv, e_dd, e_derr;
    g = -1;
    if (!reset && bus.mem_ready) begin
      if (bus.if_req && bus.d_req) g = (m_last == 0) ? 1 : 0;
      else if (bus.if_req)         g = 0;
      else if (bus.d_req)          g = 1;
    end
    e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0;
    e_ifv = 0; e_ifd = 0; e_dv = 0; e_dd = 0; e_derr = 0;
    if (g == 0) begin
      e_en   = 1;
      e_addr = (64'(bus.if_addr) / 4) % 64;
    end else if (g == 1) begin
      e_en    = (bus.d_addr % 4 == 0) ? 1 : 0;
      e_we    = 64'(bus.d_we);
      e_addr  = (64'(bus.d_addr) / 4) % 64;
      e_wdata = 64'(bus.d_wdata);
    end
    if (!reset) begin
      if (m_pend == 1) begin e_ifv = 1; e_ifd = 64'(bus.mem_rdata); end
      if (m_pend == 2) begin e_dv = 1;  e_dd  = 64'(bus.mem_rdata); end
      if (m_pend == 3) begin e_dv = 1;  e_derr = 1; end
    end
    @(negedge clk);
    s_if_gnt = bus.if_gnt;     s_d_gnt = bus.d_gnt;
    s_mem_en = bus.mem_en;     s_mem_we = bus.mem_we;   s_mem_addr = bus.mem_addr;
    s_if_rvalid = bus.if_rvalid; s_if_rdata = bus.if_rdata;
    s_d_rvalid = bus.d_rvalid; s_d_rdata = bus.d_rdata; s_d_err = bus.d_err;
    check_val("if_gnt", 64'(s_if_gnt), (g == 0) ? 64'd1 : 64'd0);
    check_val("d_gnt",  64'(s_d_gnt),  (g == 1) ? 64'd1 : 64'd0);
    check_val("mem_en", 64'(s_mem_en), e_en);
    if (g != -1 || reset) begin
      check_val("mem_we",    64'(s_mem_we),      e_we);
      check_val("mem_addr",  64'(s_mem_addr),    e_addr);
      check_val("mem_wdata", 64'(bus.mem_wdata), e_wdata);
    end
    check_val("if_rvalid", 64'(s_if_rvalid), e_ifv);
    check_val("if_rdata",  64'(s_if_rdata),  e_ifd);
    check_val("d_rvalid",  64'(s_d_rvalid),  e_dv);
    check_val("d_rdata",   64'(s_d_rdata),   e_dd);
    check_val("d_err",     64'(s_d_err),     e_derr);
    @(posedge clk);
    if (reset) begin
      m_last = 0;
      m_pend = 0;
    end else begin
      m_pend = 0;
      if (g == 0) begin
        m_last = 0;
        m_pend = 1;
      end else if (g == 1) begin
        m_last = 1;
        if (bus.d_addr % 4 != 0) m_pend = 3;
        else if (!bus.d_we)      m_pend = 2;
      end
    end
    last_g = g;
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    reset = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
    bus.d_req = 1'b1;  bus.d_we = 1'b1; bus.d_addr = 32'h0000_0020; bus.d_wdata = 32'h1234_5678;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hA5A5_A5A5;

    // Outputs held at zero while reset is asserted, even with requests pending.
    run_cycle();
    run_cycle();
    reset = 1'b0;

    // Conflict held four cycles: D, IF, D, IF with the memory strobed every cycle.
    bus.d_we = 1'b0; bus.d_addr = 32'h0000_0004; bus.if_addr = 32'h0000_0008;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      check_val("rr_d_gnt", 64'(s_d_gnt), (i % 2 == 0) ? 64'd1 : 64'd0);
      check_val("rr_mem_en", 64'(s_mem_en), 64'd1);
    end

    // Aligned data read of word 2 returns memory data one cycle later.
    bus.if_req = 1'b0; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0008;
    run_cycle();
    check_val("rd_gnt", 64'(s_d_gnt), 64'd1);
    check_val("rd_addr", 64'(s_mem_addr), 64'd2);
    bus.d_req = 1'b0; bus.mem_rdata = 32'hDEAD_BEEF;
    run_cycle();
    check_val("rd_rvalid", 64'(s_d_rvalid), 64'd1);
    check_val("rd_rdata", 64'(s_d_rdata), 64'hDEAD_BEEF);

    // Memory not ready for three cycles, then the fetch goes through.
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0030; bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      check_val("stall_gnt", 64'(s_if_gnt), 64'd0);
      check_val("stall_en", 64'(s_mem_en), 64'd0);
    end
    bus.mem_ready = 1'b1;
    run_cycle();
    check_val("stall_rel_gnt", 64'(s_if_gnt), 64'd1);
    bus.if_req = 1'b0; bus.mem_rdata = 32'hCAFE_0001;
    run_cycle();
    check_val("stall_rvalid", 64'(s_if_rvalid), 64'd1);

    // Misaligned write: granted, no strobe, error response next cycle.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0006; bus.d_wdata = 32'h0BAD_F00D;
    run_cycle();
    check_val("mis_gnt", 64'(s_d_gnt), 64'd1);
    check_val("mis_en", 64'(s_mem_en), 64'd0);
    bus.d_req = 1'b0; bus.mem_rdata = 32'hFFFF_FFFF;
    run_cycle();
    check_val("mis_rvalid", 64'(s_d_rvalid), 64'd1);
    check_val("mis_err", 64'(s_d_err), 64'd1);
    check_val("mis_rdata", 64'(s_d_rdata), 64'd0);

    // Write beyond the memory size wraps to word 1 and produces no response.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0104;
    run_cycle();
    check_val("wrap_addr", 64'(s_mem_addr), 64'd1);
    check_val("wrap_we", 64'(s_mem_we), 64'd1);
    bus.d_req = 1'b0;
    run_cycle();
    check_val("wrap_no_rvalid", 64'(s_d_rvalid), 64'd0);

    // Fetch granted, reset the next cycle: its response is discarded.
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
    run_cycle();
    reset = 1'b1; bus.if_req = 1'b0;
    run_cycle();
    check_val("rst_if_rvalid", 64'(s_if_rvalid), 64'd0);
    reset = 1'b0;
    run_cycle();
    check_val("rst_after_rvalid", 64'(s_if_rvalid), 64'd0);

    // Data wins last, then reset: the first conflict afterwards still goes to data.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0010;
    run_cycle();
    reset = 1'b1; bus.d_req = 1'b0;
    run_cycle();
    check_val("rst_d_rvalid", 64'(s_d_rvalid), 64'd0);
    reset = 1'b0; bus.if_req = 1'b1; bus.d_req = 1'b1;
    run_cycle();
    check_val("rst_first_conflict", 64'(s_d_gnt), 64'd1);

    // Randomized traffic; ungranted requests are held with their address and data.
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!bus.if_req || last_g == 0) begin
        bus.if_req  = 1'($urandom_range(0, 1));
        bus.if_addr = rand_addr();
      end
      if (!bus.d_req || last_g == 1) begin
        bus.d_req   = 1'($urandom_range(0, 1));
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = rand_addr();
        bus.d_wdata = $urandom;
      end
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      bus.mem_rdata = $urandom;
      reset         = ($urandom_range(0, 49) == 0);
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
